// File: rtl/pcss_spk_collector.sv
// -----------------------------------------------------------------------------
// pcss_spk_collector
//
// Receive-side collector sitting behind pcss_inf. It takes the 64-bit stream of
// chip output words and groups them into tik windows. At every tik falling edge
// it inserts a boundary header. Everything is buffered in a first-word-fall-
// through FIFO toward the host DMA stream. An all-ones completion marker is
// replaced by an end header that carries tlast, and it sets a sticky done flag.
//
// Header layout (64 bit):
//   [63:48] tag       E1C0 = tik boundary, E1ED = end of run
//   [47:32] tik count  zero-extended
//   [31:16] 0
//   [15:0]  window word count (saturating)
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   tik         chip tik, synchronous to clk
//   s_t*        input stream (s_tkeep is ignored)
//   m_t*        output stream toward DMA; m_tkeep is constant 8'hFF
//   done        sticky, the completion marker has been received
//   hdr_ovf     sticky, a tik header was dropped because one was still pending
//   tik_cnt     number of completed tik windows, wraps
// -----------------------------------------------------------------------------
module pcss_spk_collector #(
    parameter int DATA_WIDTH = 64,
    parameter int TIK_CNT    = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tik,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [7:0]            s_tkeep,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    output logic [7:0]            m_tkeep,
    input  logic                  m_tready,
    output logic                  done,
    output logic                  hdr_ovf,
    output logic [TIK_CNT-1:0]    tik_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]         PTR_ONE = 1;
    localparam logic [TIK_CNT-1:0]  TIK_ONE = 1;
    localparam logic [15:0]         TAG_TIK = 16'hE1C0;
    localparam logic [15:0]         TAG_END = 16'hE1ED;

    // FIFO storage and pointers (extra wrap bit distinguishes full from empty)
    logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;

    // Tik tracking and pending headers
    logic                  r_tik_dly;
    logic [TIK_CNT-1:0]    r_tik_cnt;
    logic [15:0]           r_win_cnt;
    logic                  r_hdr_pend;
    logic [DATA_WIDTH-1:0] r_hdr_word;
    logic                  r_end_pend;
    logic [DATA_WIDTH-1:0] r_end_word;
    logic                  r_done;
    logic                  r_hdr_ovf;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_fall;
    logic                  w_accept;
    logic                  w_marker;
    logic                  w_data_acc;
    logic [15:0]           w_win_inc;
    logic [15:0]           w_win_hdr;
    logic [15:0]           w_tik16;
    logic [15:0]           w_tik16_next;
    logic                  w_wr_en;
    logic [DATA_WIDTH:0]   w_wr_entry;
    logic                  w_hdr_wr;
    logic                  w_end_wr;
    logic                  w_rd_en;
    logic [DATA_WIDTH:0]   w_rd_entry;
    logic                  w_unused;

    assign w_unused = ^s_tkeep;

    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fall  = r_tik_dly & ~tik;

    // Ready depends only on state, never on s_tvalid; held low during reset.
    assign s_tready   = ~rst & ~w_full & ~r_hdr_pend & ~r_end_pend & ~r_done;
    assign w_accept   = s_tvalid & s_tready;
    assign w_marker   = w_accept & (s_tdata == {DATA_WIDTH{1'b1}});
    assign w_data_acc = w_accept & ~w_marker;

    assign w_win_inc    = (r_win_cnt == 16'hFFFF) ? r_win_cnt : r_win_cnt + 16'd1;
    // Header count includes a word accepted in the same cycle as the fall.
    assign w_win_hdr    = w_data_acc ? w_win_inc : r_win_cnt;
    assign w_tik16      = 16'(r_tik_cnt);
    assign w_tik16_next = 16'(r_tik_cnt + TIK_ONE);

    // Single FIFO write port: tik header, then end header, then input data.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_wr_en    = 1'b0;
        w_wr_entry = '0;
        if (!w_full) begin
            if (r_hdr_pend) begin
                w_wr_en    = 1'b1;
                w_wr_entry = {1'b0, r_hdr_word};
            end else if (r_end_pend) begin
                w_wr_en    = 1'b1;
                w_wr_entry = {1'b1, r_end_word};
            end else if (w_data_acc) begin
                w_wr_en    = 1'b1;
                w_wr_entry = {1'b0, s_tdata};
            end
        end
    end

    assign w_hdr_wr = w_wr_en & r_hdr_pend;
    assign w_end_wr = w_wr_en & ~r_hdr_pend & r_end_pend;
    assign w_rd_en  = m_tready & ~w_empty;

    // NOTE: the storage array has no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tik_dly  <= 1'b0;
            r_tik_cnt  <= '0;
            r_win_cnt  <= '0;
            r_hdr_pend <= 1'b0;
            r_hdr_word <= '0;
            r_end_pend <= 1'b0;
            r_end_word <= '0;
            r_done     <= 1'b0;
            r_hdr_ovf  <= 1'b0;
        end else begin
            r_tik_dly <= tik;

            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;

            if (w_fall) begin
                r_tik_cnt <= r_tik_cnt + TIK_ONE;
                r_win_cnt <= '0;
            end else if (w_data_acc) begin
                r_win_cnt <= w_win_inc;
            end

            // A fall while a header is still pending loses the new header.
            if (w_fall && !r_hdr_pend) begin
                r_hdr_pend <= 1'b1;
                r_hdr_word <= {TAG_TIK, w_tik16, 16'h0000, w_win_hdr};
            end else if (w_hdr_wr) begin
                r_hdr_pend <= 1'b0;
            end
            if (w_fall && r_hdr_pend) begin
                r_hdr_ovf <= 1'b1;
            end

            // A marker coinciding with a fall belongs to the new, empty window.
            if (w_marker) begin
                r_end_pend <= 1'b1;
                r_done     <= 1'b1;
                r_end_word <= w_fall ? {TAG_END, w_tik16_next, 16'h0000, 16'h0000}
                                     : {TAG_END, w_tik16, 16'h0000, r_win_cnt};
            end else if (w_end_wr) begin
                r_end_pend <= 1'b0;
            end
        end
    end

    // First-word-fall-through read side; data forced to zero when empty.
    assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];
    assign m_tvalid   = ~w_empty;
    assign m_tdata    = w_empty ? '0 : w_rd_entry[DATA_WIDTH-1:0];
    assign m_tlast    = w_empty ? 1'b0 : w_rd_entry[DATA_WIDTH];
    assign m_tkeep    = 8'hFF;
    assign done       = r_done;
    assign hdr_ovf    = r_hdr_ovf;
    assign tik_cnt    = r_tik_cnt;

endmodule

// File: tb/tb_pcss_spk_collector.sv
// -----------------------------------------------------------------------------
// Testbench for pcss_spk_collector: a cycle table for the basic window flow,
// then hand-written sequences for back-pressure, completion, header overflow
// and mid-stream reset. Output words are captured into a queue and compared
// against an expected queue built by the bench.
// -----------------------------------------------------------------------------
module tb_pcss_spk_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tik = 1'b0;
    logic [63:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  s_tkeep = 8'h00;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [7:0]  m_tkeep;
    logic        m_tready = 1'b0;
    logic        done;
    logic        hdr_ovf;
    logic [7:0]  tik_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    logic [64:0] got_q[$];
    logic [64:0] exp_q[$];

    pcss_spk_collector #(
        .DATA_WIDTH (64),
        .TIK_CNT    (8),
        .FIFO_DEPTH (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tik      (tik),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tkeep  (s_tkeep),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tkeep  (m_tkeep),
        .m_tready (m_tready),
        .done     (done),
        .hdr_ovf  (hdr_ovf),
        .tik_cnt  (tik_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; handshakes are sampled 1 ns before the rising edge.
    always @(negedge clk) begin
        #4;
        if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
    end

    typedef struct {
        logic        tik;
        logic        vld;
        logic [63:0] data;
        logic        exp_sready;
        logic        exp_mvalid;
        logic [63:0] exp_mdata;
        logic        exp_mlast;
        logic [7:0]  exp_tikcnt;
    } vec_t;

    vec_t vec [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        rst = 1'b1; tik = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
        #1;
        if (chk) begin
            check("reset_outputs",
                  {s_tready, m_tvalid, m_tdata, m_tlast, done, hdr_ovf, tik_cnt, m_tkeep},
                  {1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF});
        end
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_tvalid = 1'b0;
            tik = 1'b0;
        end
    endtask

    // Presents a word and returns just before the edge that accepts it.
    task automatic send(input logic [63:0] w);
        bit ok = 1'b0;
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = w;
        for (int i = 0; i < 60; i++) begin
            #4;
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("send_timeout", {64'h0, w}, {64'h1, w});
    endtask

    task automatic tik_pulse();
        @(negedge clk);
        s_tvalid = 1'b0;
        tik = 1'b1;
        @(negedge clk);
        tik = 1'b0;
    endtask

    task automatic compare_stream(input string name);
        int n;
        check({name, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_word%0d", name, i), 128'(got_q[i]), 128'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Cycle table for three words and one tik pulse, m_tready held high.
        vec[0] = '{1'b0, 1'b1, 64'h1, 1'b1, 1'b0, 64'h0, 1'b0, 8'd0};
        vec[1] = '{1'b0, 1'b1, 64'h2, 1'b1, 1'b1, 64'h1, 1'b0, 8'd0};
        vec[2] = '{1'b0, 1'b1, 64'h3, 1'b1, 1'b1, 64'h2, 1'b0, 8'd0};
        vec[3] = '{1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 64'h3, 1'b0, 8'd0};
        vec[4] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 8'd0};
        vec[5] = '{1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 8'd1};
        vec[6] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'hE1C0_0000_0000_0003, 1'b0, 8'd1};
        vec[7] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 8'd1};

        do_reset(1'b1);
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tik = vec[i].tik;
            s_tvalid = vec[i].vld;
            s_tdata = vec[i].data;
            #1;
            check($sformatf("t1_cycle%0d", i),
                  {s_tready, m_tvalid, vec[i].exp_mvalid ? m_tdata : 64'h0, m_tlast, tik_cnt},
                  {vec[i].exp_sready, vec[i].exp_mvalid, vec[i].exp_mdata, vec[i].exp_mlast,
                   vec[i].exp_tikcnt});
        end
        idle(2);

        // Two empty windows.
        do_reset(1'b0);
        m_tready = 1'b1;
        tik_pulse();
        idle(3);
        tik_pulse();
        idle(6);
        exp_q.push_back({1'b0, 64'hE1C0_0000_0000_0000});
        exp_q.push_back({1'b0, 64'hE1C0_0001_0000_0000});
        compare_stream("t2");
        check("t2_hdr_ovf", 128'(hdr_ovf), 128'(0));

        // Back-pressure: ready drops once the FIFO holds 16 words.
        do_reset(1'b0);
        m_tready = 1'b0;
        for (int i = 1; i <= 16; i++) send(64'(i));
        @(negedge clk);
        s_tvalid = 1'b0;
        #1;
        check("t3_sready_full", 128'(s_tready), 128'(0));
        m_tready = 1'b1;
        for (int i = 17; i <= 20; i++) send(64'(i));
        idle(30);
        for (int i = 1; i <= 20; i++) exp_q.push_back({1'b0, 64'(i)});
        compare_stream("t3");

        // Completion marker after five windows and two words.
        do_reset(1'b0);
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tik_pulse();
            idle(3);
            exp_q.push_back({1'b0, 64'hE1C0_0000_0000_0000 | (64'(i) << 32)});
        end
        send(64'h1);
        send(64'h2);
        send(64'hFFFF_FFFF_FFFF_FFFF);
        idle(1);
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata = 64'h5;
        #1;
        check("t4_done", 128'(done), 128'(1));
        check("t4_sready_blocked", 128'(s_tready), 128'(0));
        idle(5);
        tik_pulse();
        idle(6);
        exp_q.push_back({1'b0, 64'h1});
        exp_q.push_back({1'b0, 64'h2});
        exp_q.push_back({1'b1, 64'hE1ED_0005_0000_0002});
        exp_q.push_back({1'b0, 64'hE1C0_0005_0000_0002});
        compare_stream("t4");
        check("t4_tik_cnt", 128'(tik_cnt), 128'(6));
        check("t4_sready_after", 128'(s_tready), 128'(0));

        // Header overflow while the FIFO is held full.
        do_reset(1'b0);
        m_tready = 1'b0;
        for (int i = 1; i <= 16; i++) send(64'h100 + 64'(i));
        tik_pulse();
        idle(2);
        check("t5_ovf_after_first", 128'(hdr_ovf), 128'(0));
        tik_pulse();
        idle(2);
        check("t5_ovf_after_second", 128'(hdr_ovf), 128'(1));
        m_tready = 1'b1;
        idle(30);
        for (int i = 1; i <= 16; i++) exp_q.push_back({1'b0, 64'h100 + 64'(i)});
        exp_q.push_back({1'b0, 64'hE1C0_0000_0000_0010});
        compare_stream("t5");
        check("t5_tik_cnt", 128'(tik_cnt), 128'(2));

        // Reset in the middle of a half-full FIFO.
        do_reset(1'b0);
        m_tready = 1'b0;
        for (int i = 1; i <= 8; i++) send(64'h200 + 64'(i));
        idle(1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_mvalid_in_reset", {m_tvalid, tik_cnt}, {1'b0, 8'd0});
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        m_tready = 1'b1;
        send(64'hAB);
        tik_pulse();
        idle(8);
        exp_q.push_back({1'b0, 64'hAB});
        exp_q.push_back({1'b0, 64'hE1C0_0000_0000_0001});
        compare_stream("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pcss_spk_collector.md
Name: pcss_spk_collector

Overview:
- Receive-side stage directly downstream of pcss_inf. Consumes the 64-bit AXI-stream of chip output words (M_AXIS_recv of pcss_inf).
- Groups the words into tik windows, inserts a boundary header word at every tik falling edge, and buffers everything in a FIFO toward the host DMA stream.
- Detects the all-ones completion marker, converts it into a final header carrying tlast, and raises a sticky done flag.

Parameters:
DATA_WIDTH, 64, stream word width; fixed at 64 (header layout depends on it).
TIK_CNT, 8, tik counter width (1..16).
FIFO_DEPTH, 16, buffer entries; power of two, >=4.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
tik  in  1  chip tik signal, synchronous to clk
s_tdata  in  64  word from pcss_inf
s_tvalid  in  1  input valid
s_tready  out  1  input ready
s_tkeep  in  8  ignored
m_tdata  out  64  output word
m_tvalid  out  1  output valid
m_tlast  out  1  last word of run
m_tkeep  out  8  constant 8'hFF
m_tready  in  1  output ready
done  out  1  sticky; completion marker received
hdr_ovf  out  1  sticky; a tik header was dropped
tik_cnt  out  TIK_CNT  completed tik windows, wraps

Behaviour:
Reset:
- All outputs are 0 except m_tkeep=8'hFF.
- FIFO is empty; all pending flags, counters and tik_dly are cleared.
- Assertion mid-operation discards FIFO contents immediately.

Tik edge and window counting:
- tik_dly<=tik every cycle; fall = tik_dly & ~tik.
- On fall, tik_cnt<=tik_cnt+1 (wraps).
- win_cnt (16 bit, saturating at FFFF) counts accepted non-marker input words since the last fall.

Tik header:
- On fall, if hdr_pend=0: latch hdr_word={16'hE1C0, zero-extended old tik_cnt (16b), 16'h0000, win_cnt including any word accepted the same cycle}, set hdr_pend, clear win_cnt.
- On fall with hdr_pend=1: the new header is dropped, hdr_ovf<=1, win_cnt is still cleared.

End header:
- Marker = an accepted word equal to all ones. It is never written to the FIFO.
- Marker sets done and end_pend, and latches end_word={16'hE1ED, zero-extended tik_cnt, 16'h0000, win_cnt}.

FIFO write arbitration (one write per cycle), in priority order:
1. hdr_pend, last=0.
2. end_pend, only when hdr_pend=0, last=1.
3. Input word.
- A pending flag clears when its write happens.

Input handshake:
- s_tready = ~full & ~hdr_pend & ~end_pend & ~done. This is combinational from registers only; it has no path from s_tvalid.
- Accept = s_tvalid & s_tready. Non-marker words are written with last=0.

Simultaneous events:
- Fall and marker in the same cycle: the marker word is counted in neither header. The tik header is written first, then the end header.
- Fall while end_pend: the tik header still takes priority.

FIFO and output:
- 65-bit entries {last,data}, first-word-fall-through.
- A write appears on m_tvalid the next cycle (1-cycle latency).
- Full and empty come from pointers with an extra wrap bit.
- Simultaneous read and write when full: the read happens, the write is refused by full. Pending headers wait.
- m_tdata/m_tlast are held stable while m_tvalid & ~m_tready.

After done:
- Input is blocked until reset.
- tik headers continue to be generated and drained.

Test Plan:
1. Reset; 3 words 0x1..0x3 accepted, then one tik pulse; m_tready=1 -> output 0x1, 0x2, 0x3, then E1C0_0000_0000_0003; tik_cnt=1.
2. Two tik pulses with no input -> headers E1C0_0000_0000_0000 then E1C0_0001_0000_0000; hdr_ovf=0.
3. m_tready=0; 20 words driven -> s_tready drops after 16 accepted. Raise m_tready -> 16 words in order, then the remaining 4, with no loss or duplication.
4. Marker 0xFFFF_FFFF_FFFF_FFFF arriving after 2 words, tik_cnt=5 -> output E1ED_0005_0000_0002 with m_tlast=1; done=1; s_tready stays 0.
5. FIFO held full with m_tready=0 across 2 tik falls -> first header kept, second dropped, hdr_ovf=1. After drain exactly one header is output.
6. Reset asserted mid-stream with FIFO half full -> m_tvalid=0 immediately. After release, a new word is output alone with correct count in the next header.
